// File: rtl/seven_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_display_ctrl
//  Purpose  : Avalon-MM slave driving NUM_DIGITS active-low seven-segment
//             displays with hex decode, enables, DPs, LZ blanking and blink.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_HZ   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic [8*NUM_DIGITS-1:0] hex_n
);

    localparam int C_HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
    localparam int C_CNT_W       = (C_HALF_PERIOD > 1) ? $clog2(C_HALF_PERIOD) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_HALF_PERIOD - 1);

    localparam logic [1:0] C_ADDR_VALUE = 2'd0;
    localparam logic [1:0] C_ADDR_CTRL  = 2'd1;
    localparam logic [1:0] C_ADDR_BLINK = 2'd2;
    localparam logic [1:0] C_ADDR_INFO  = 2'd3;

    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic                    r_lzb;
    logic [NUM_DIGITS-1:0]   r_blink;
    logic [C_CNT_W-1:0]      r_cnt;
    logic                    r_phase;
    logic [31:0]             r_readdata;
    logic [8*NUM_DIGITS-1:0] r_hex_n;

    logic                    w_wr;
    logic                    w_rd;
    logic [31:0]             w_rdata;
    logic [NUM_DIGITS-1:0]   w_nonzero;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [8*NUM_DIGITS-1:0] w_hex_nxt;
    logic                    w_unused_wdata;

    assign w_wr           = chipselect & write;
    assign w_rd           = chipselect & read;
    assign w_unused_wdata = &{1'b0, writedata};

    function automatic logic [6:0] seg_decode(input logic [3:0] i_nib);
        logic [6:0] v;
        case (i_nib)
            4'h0: v = 7'h3F;
            4'h1: v = 7'h06;
            4'h2: v = 7'h5B;
            4'h3: v = 7'h4F;
            4'h4: v = 7'h66;
            4'h5: v = 7'h6D;
            4'h6: v = 7'h7D;
            4'h7: v = 7'h07;
            4'h8: v = 7'h7F;
            4'h9: v = 7'h6F;
            4'hA: v = 7'h77;
            4'hB: v = 7'h7C;
            4'hC: v = 7'h39;
            4'hD: v = 7'h5E;
            4'hE: v = 7'h79;
            default: v = 7'h71;
        endcase
        return v;
    endfunction

    // Register file; the BLINK write also restarts the blink timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_en    <= '1;
            r_dp    <= '0;
            r_lzb   <= 1'b0;
            r_blink <= '0;
        end else if (w_wr) begin
            case (address)
                C_ADDR_VALUE: r_value <= writedata[4*NUM_DIGITS-1:0];
                C_ADDR_CTRL: begin
                    r_en  <= writedata[NUM_DIGITS-1:0];
                    r_dp  <= writedata[8+NUM_DIGITS-1:8];
                    r_lzb <= writedata[16];
                end
                C_ADDR_BLINK: r_blink <= writedata[NUM_DIGITS-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (w_wr && address == C_ADDR_BLINK)) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == C_CNT_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            C_ADDR_VALUE: w_rdata[4*NUM_DIGITS-1:0] = r_value;
            C_ADDR_CTRL: begin
                w_rdata[NUM_DIGITS-1:0]   = r_en;
                w_rdata[8+NUM_DIGITS-1:8] = r_dp;
                w_rdata[16]               = r_lzb;
            end
            C_ADDR_BLINK: begin
                w_rdata[NUM_DIGITS-1:0] = r_blink;
                w_rdata[31]             = r_phase;
            end
            C_ADDR_INFO: w_rdata[3:0] = 4'(NUM_DIGITS);
            default: ;
        endcase
    end

    // Read data is captured from pre-write state, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

    // A digit is LZ-blanked when no enabled digit at or above it is non-zero.
    generate
        for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
            assign w_nonzero[d] = r_en[d] && (r_value[4*d +: 4] != 4'h0);

            if (d == 0) begin : g_lsd
                assign w_lz_blank[d] = 1'b0;
            end else begin : g_upper
                assign w_lz_blank[d] = r_lzb && !(|(w_nonzero >> d));
            end

            always_comb begin
                if (!r_en[d]) begin
                    w_hex_nxt[8*d +: 8] = 8'hFF;
                end else if (r_blink[d] && r_phase) begin
                    w_hex_nxt[8*d +: 8] = 8'hFF;
                end else if (w_lz_blank[d]) begin
                    w_hex_nxt[8*d +: 8] = {~r_dp[d], 7'h7F};
                end else begin
                    w_hex_nxt[8*d +: 8] = {~r_dp[d], ~seg_decode(r_value[4*d +: 4])};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex_n <= '1;
        end else begin
            r_hex_n <= w_hex_nxt;
        end
    end

    assign readdata = r_readdata;
    assign hex_n    = r_hex_n;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_display_ctrl
//  Purpose  : Directed self-checking bench for seven_seg_display_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [47:0] hex_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seven_seg_display_ctrl #(
        .NUM_DIGITS (6),
        .CLK_HZ     (8),
        .BLINK_HZ   (1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .hex_n      (hex_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0;
        write = 1'b0; writedata = 32'h0; read = 1'b0;
        tick(); tick();
        check("rst_hex", hex_n, 64'h0000_FFFF_FFFF_FFFF);
        check("rst_rdata", readdata, 64'h0);

        reset = 1'b0;
        tick();
        check("first_hex", hex_n, 64'h0000_C0C0_C0C0_C0C0);
        rd("info", 2'd3, 32'h6);
        rd("ctrl_rst", 2'd1, 32'h3F);
        tick(); tick();
        check("rdata_hold", readdata, 64'h3F);

        // Hex decode of A..F
        wr(2'd0, 32'h00FEDCBA);
        tick();
        check("dec_af", hex_n, 64'h0000_8E86_A1C6_8388);
        rd("value_rb", 2'd0, 32'h00FEDCBA);

        // LZB with all zeros: digit 0 kept and shows its DP
        wr(2'd1, 32'h0001_013F);
        wr(2'd0, 32'h0);
        tick();
        check("lzb_zero", hex_n, 64'h0000_FFFF_FFFF_FF40);
        rd("ctrl_rb", 2'd1, 32'h0001_013F);

        // LZB keeps interior zero
        wr(2'd1, 32'h0001_003F);
        wr(2'd0, 32'h0000_0105);
        tick();
        check("lzb_105", hex_n, 64'h0000_FFFF_FFF9_C092);

        // Disabled digit 2 (holding 1) is skipped by the scan
        wr(2'd1, 32'h0001_001B);
        tick();
        check("lzb_skip", hex_n, 64'h0000_FFFF_FFFF_FF92);

        // Mask bits above NUM_DIGITS ignored; all DPs on
        wr(2'd1, 32'h0000_FFFF);
        tick();
        check("dp_all", hex_n, 64'h0000_4040_4079_4012);
        rd("ctrl_mask", 2'd1, 32'h0000_3F3F);

        wr(2'd3, 32'hFFFF_FFFF);
        rd("info_ro", 2'd3, 32'h6);

        wr(2'd1, 32'h0000_003F);
        tick();
        check("plain", hex_n, 64'h0000_C0C0_C0F9_C092);

        // Blink on digit 0: 4 normal edges, then dark
        wr(2'd2, 32'h1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("blink_%0d", i), {56'h0, hex_n[7:0]}, (i <= 4) ? 64'h92 : 64'hFF);
        end
        rd("blink_phase1", 2'd2, 32'h8000_0001);
        check("blink_dark", {56'h0, hex_n[7:0]}, 64'hFF);
        // Rewrite lands on the same edge as the toggle; the write wins
        wr(2'd2, 32'h1);
        check("blink_rewr", {56'h0, hex_n[7:0]}, 64'hFF);
        tick();
        check("blink_restore", {56'h0, hex_n[7:0]}, 64'h92);
        rd("blink_phase0", 2'd2, 32'h0000_0001);

        // Same-cycle read and write of VALUE
        address = 2'd0; writedata = 32'h0000_0ABC;
        chipselect = 1'b1; write = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        check("rw_old", readdata, 64'h0000_0105);
        rd("rw_new", 2'd0, 32'h0000_0ABC);

        // Reset mid-blink, with a read pending
        tick(); tick(); tick();
        reset = 1'b1; address = 2'd0; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        check("rst2_hex", hex_n, 64'h0000_FFFF_FFFF_FFFF);
        check("rst2_rdata", readdata, 64'h0);
        reset = 1'b0;
        tick();
        check("rst2_first", hex_n, 64'h0000_C0C0_C0C0_C0C0);
        rd("rst2_value", 2'd0, 32'h0);
        rd("rst2_ctrl", 2'd1, 32'h3F);
        address = 2'd2; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        check("rst2_blink", {56'h0, readdata[7:0]}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
